key_debounce_pulse: RTL and testbench

- Upstream conditioning stage for the board switches/keys that drive the LFSR "next" input and similar step inputs.
- Synchronises a raw, bouncing key into the single clock domain, filters bounce and produces a clean debounced level.
- Emits one-cycle press/release pulses, plus auto-repeat press pulses while the key is held.
- Downstream blocks advance exactly once per press instead of once per bounce edge.

---
 rtl/key_pkg.sv | 26 ++
 rtl/key_debounce_pulse_if.sv | 27 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/key_debounce_pulse.sv | 116 +++++++++++
 tb/tb_key_debounce_pulse.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key debounce/pulse block: FSM state encoding
// and the sizing helper for the single shared counter.
package key_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } key_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Width needed to hold every terminal count of the shared counter.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = max3(a, b, c);
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_pulse_if.sv
// Key-side signal bundle: the raw switch going in and the conditioned
// level/pulse outputs coming back.
interface key_debounce_pulse_if;

    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;
    logic repeat_active;

    modport master (
        output key_in,
        input  key_level,
        input  key_press,
        input  key_release,
        input  repeat_active
    );

    modport slave (
        input  key_in,
        output key_level,
        output key_press,
        output key_release,
        output repeat_active
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a raw asynchronous input; the reset value lets
// each switch come out of reset already at its idle level.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces one raw key and turns it into a clean level plus one-cycle
// press/release pulses, with auto-repeat press pulses while held.
module key_debounce_pulse
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 500000,
    parameter int REPEAT_DELAY_CYCLES = 25000000,
    parameter int REPEAT_RATE_CYCLES  = 5000000,
    parameter int KEY_ACTIVE_LOW      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    key_debounce_pulse_if.slave  kif
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);

    localparam logic          RAW_IDLE   = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam bit            REPEAT_EN  = (REPEAT_DELAY_CYCLES != 0);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE_CYCLES - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);

    logic          raw_sync;
    logic          sample;
    key_state_t    state, next_state;
    logic [CW-1:0] count, count_next;
    logic          level_next, press_next, release_next, repeat_next;

    sync_2ff #(
        .RESET_VALUE (RAW_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (kif.key_in),
        .q   (raw_sync)
    );

    assign sample = raw_sync ^ RAW_IDLE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            count             <= '0;
            kif.key_level     <= 1'b0;
            kif.key_press     <= 1'b0;
            kif.key_release   <= 1'b0;
            kif.repeat_active <= 1'b0;
        end else begin
            state             <= next_state;
            count             <= count_next;
            kif.key_level     <= level_next;
            kif.key_press     <= press_next;
            kif.key_release   <= release_next;
            kif.repeat_active <= repeat_next;
        end
    end

    // A bounce back during RELEASE_WAIT returns to HELD, restarting the repeat delay.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (sample) next_state = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!sample)                next_state = IDLE;
                else if (count == DEB_LAST) next_state = HELD;
            end
            HELD: begin
                if (!sample)                                next_state = RELEASE_WAIT;
                else if (REPEAT_EN && count == DELAY_LAST)  next_state = REPEAT;
            end
            REPEAT: begin
                if (!sample) next_state = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (sample)                 next_state = HELD;
                else if (count == DEB_LAST) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counter is cleared on every transition and never runs past its terminal count.
    always_comb begin
        count_next   = '0;
        press_next   = 1'b0;
        release_next = 1'b0;
        level_next   = (next_state == HELD) || (next_state == REPEAT) ||
                       (next_state == RELEASE_WAIT);
        repeat_next  = (next_state == REPEAT);

        if (next_state == state) begin
            unique case (state)
                IDLE:   count_next = '0;
                HELD:   count_next = REPEAT_EN ? (count + ONE) : count;
                REPEAT: begin
                    if (count == RATE_LAST) begin
                        count_next = '0;
                        press_next = 1'b1;
                    end else begin
                        count_next = count + ONE;
                    end
                end
                default: count_next = count + ONE;
            endcase
        end

        if (state == PRESS_WAIT && next_state == HELD)   press_next   = 1'b1;
        if (state == HELD && next_state == REPEAT)       press_next   = 1'b1;
        if (state == RELEASE_WAIT && next_state == IDLE) release_next = 1'b1;
    end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench for key_debounce_pulse: expected pulses are queued with
// their edge number, and per-instance monitors pop and compare each pulse.
module tb_key_debounce_pulse;

    typedef struct {
        bit is_press;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   edge_cnt;
    int   checks;
    int   fails;
    exp_t q0[$];
    exp_t q1[$];

    key_debounce_pulse_if kif0 ();
    key_debounce_pulse_if kif1 ();

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (20),
        .REPEAT_RATE_CYCLES  (8),
        .KEY_ACTIVE_LOW      (0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .kif (kif0)
    );

    key_debounce_pulse #(
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (20),
        .REPEAT_RATE_CYCLES  (8),
        .KEY_ACTIVE_LOW      (1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .kif (kif1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check_output(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            fails++;
            $display("[TB] FAIL %s: actual %0d, required %0d (edge %0d)", name, actual, required, edge_cnt);
        end
    endtask

    task automatic wait_until(input int t);
        while (edge_cnt < t) @(negedge clk);
    endtask

    // Drives the raw key of one instance at a negedge; base is the next edge ("edge 0").
    task automatic apply_stimulus(input int idx, input logic val, output int base);
        if (idx == 0) kif0.key_in = val;
        else          kif1.key_in = val;
        base = edge_cnt + 1;
    endtask

    task automatic expect_pulse(input int idx, input bit is_press, input int cyc);
        exp_t e;
        e.is_press = is_press;
        e.cyc      = cyc;
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic monitor_step(input int idx, input logic press, input logic rel, input logic level);
        exp_t  e;
        string tag;
        bit    empty;
        tag   = (idx == 0) ? "dut0" : "dut1";
        empty = (idx == 0) ? (q0.size() == 0) : (q1.size() == 0);
        if (press && rel) check_output({tag, " press/release overlap"}, 1, 0);
        if (press || rel) begin
            if (empty) begin
                check_output({tag, " unexpected pulse at edge"}, edge_cnt, -1);
            end else begin
                if (idx == 0) e = q0.pop_front();
                else          e = q1.pop_front();
                check_output({tag, " pulse kind (1=press)"}, int'(press), int'(e.is_press));
                check_output({tag, " pulse edge"}, edge_cnt, e.cyc);
                check_output({tag, " level with pulse"}, int'(level), int'(e.is_press));
            end
        end
    endtask

    always @(negedge clk) monitor_step(0, kif0.key_press, kif0.key_release, kif0.key_level);
    always @(negedge clk) monitor_step(1, kif1.key_press, kif1.key_release, kif1.key_level);

    initial begin
        int base;
        checks      = 0;
        fails       = 0;
        rst         = 1'b0;
        kif0.key_in = 1'b0;
        kif1.key_in = 1'b1;
        #1;
        check_output("reset dut0 level",  int'(kif0.key_level), 0);
        check_output("reset dut0 press",  int'(kif0.key_press), 0);
        check_output("reset dut0 repeat", int'(kif0.repeat_active), 0);
        check_output("reset dut1 level",  int'(kif1.key_level), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        $display("[TB] reset released");

        // Bounce: 1,0,1,0 with two-cycle phases, never stable for four samples.
        apply_stimulus(0, 1'b1, base);
        wait_until(base + 1); kif0.key_in = 1'b0;
        wait_until(base + 3); kif0.key_in = 1'b1;
        wait_until(base + 5); kif0.key_in = 1'b0;
        wait_until(base + 7);
        check_output("bounce level mid", int'(kif0.key_level), 0);
        wait_until(base + 20);
        check_output("bounce level end", int'(kif0.key_level), 0);
        check_output("bounce queue empty", q0.size(), 0);

        // Clean press, auto-repeat, then release with a glitch.
        apply_stimulus(0, 1'b1, base);
        expect_pulse(0, 1'b1, base + 6);
        for (int k = 0; k < 10; k++) expect_pulse(0, 1'b1, base + 26 + 8 * k);
        wait_until(base + 6);
        check_output("press level", int'(kif0.key_level), 1);
        wait_until(base + 25);
        check_output("repeat_active before delay", int'(kif0.repeat_active), 0);
        wait_until(base + 26);
        check_output("repeat_active at delay", int'(kif0.repeat_active), 1);
        wait_until(base + 99);  kif0.key_in = 1'b0;
        wait_until(base + 100); kif0.key_in = 1'b1;
        wait_until(base + 102); kif0.key_in = 1'b0;
        expect_pulse(0, 1'b0, base + 109);
        wait_until(base + 103);
        check_output("glitch level held", int'(kif0.key_level), 1);
        check_output("glitch repeat dropped", int'(kif0.repeat_active), 0);
        wait_until(base + 120);
        check_output("release level", int'(kif0.key_level), 0);
        check_output("repeat scenario queue empty", q0.size(), 0);

        // Reset while repeating with the key still held.
        apply_stimulus(0, 1'b1, base);
        expect_pulse(0, 1'b1, base + 6);
        expect_pulse(0, 1'b1, base + 26);
        wait_until(base + 30);
        check_output("pre-reset repeat_active", int'(kif0.repeat_active), 1);
        #2 rst = 1'b0;
        #1;
        check_output("async reset level",   int'(kif0.key_level), 0);
        check_output("async reset repeat",  int'(kif0.repeat_active), 0);
        check_output("async reset press",   int'(kif0.key_press), 0);
        check_output("async reset release", int'(kif0.key_release), 0);
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        base = edge_cnt + 1;
        expect_pulse(0, 1'b1, base + 6);
        wait_until(base + 16);
        apply_stimulus(0, 1'b0, base);
        expect_pulse(0, 1'b0, base + 6);
        wait_until(base + 15);
        check_output("post-reset queue empty", q0.size(), 0);

        // Active-low instance: idle-high so far, must not have pulsed.
        check_output("active-low idle level", int'(kif1.key_level), 0);
        check_output("active-low idle queue", q1.size(), 0);
        apply_stimulus(1, 1'b0, base);
        expect_pulse(1, 1'b1, base + 6);
        wait_until(base + 12);
        check_output("active-low press level", int'(kif1.key_level), 1);
        apply_stimulus(1, 1'b1, base);
        expect_pulse(1, 1'b0, base + 6);
        wait_until(base + 12);
        check_output("active-low release level", int'(kif1.key_level), 0);
        check_output("active-low queue empty", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
